// File: rtl/multicycle_core.sv
// multicycle_core: FETCH/DECODE/EXECUTE/MEM/WB multicycle CPU with req/ack memories.
// Optional retirement trace ports are enabled by defining MC_CORE_RETIRE_EN.
module multicycle_core #(
  parameter int DATA_W = 32,
  parameter int PC_W = 16,
  parameter int DADDR_W = 16,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               enable,
  output logic               imem_req,
  output logic [PC_W-1:0]    imem_addr,
  input  logic               imem_ack,
  input  logic [31:0]        imem_rdata,
  output logic               dmem_req,
  output logic               dmem_we,
  output logic [DADDR_W-1:0] dmem_addr,
  output logic [DATA_W-1:0]  dmem_wdata,
  input  logic               dmem_ack,
  input  logic [DATA_W-1:0]  dmem_rdata,
  output logic [PC_W-1:0]    pc
`ifdef MC_CORE_RETIRE_EN
  ,
  output logic               retire_valid,
  output logic [PC_W-1:0]    retire_pc,
  output logic [31:0]        retire_inst
`endif
);

  localparam logic [2:0] OP_ST  = 3'b001;
  localparam logic [2:0] OP_JMP = 3'b011;

  typedef enum logic [2:0] {
    FETCH, DECODE, EXECUTE, MEM, WB
  } state_t;

  state_t             state;
  logic [31:0]        instr;
  logic [DATA_W-1:0]  regs [32];
  logic [DATA_W-1:0]  src_a;
  logic [DATA_W-1:0]  src_b;
  logic [DATA_W-1:0]  src_c;
  logic [DATA_W-1:0]  res;
  logic [DATA_W-1:0]  alu;

  logic [2:0]         op;
  logic [4:0]         rd;
  logic [4:0]         rs1;
  logic [4:0]         rs2;
  logic [DADDR_W-1:0] addr;
  logic [PC_W-1:0]    tgt;
  logic               is_alu;
  logic               is_mem;
  logic               is_st;
  logic               is_jmp;

  assign op   = instr[31:29];
  assign rd   = instr[28:24];
  assign rs1  = instr[23:19];
  assign rs2  = instr[18:14];
  assign addr = instr[DADDR_W-1:0];
  assign tgt  = instr[PC_W-1:0];

  assign is_alu = op[2];
  assign is_mem = (op[2:1] == 2'b00);
  assign is_st  = (op == OP_ST);
  assign is_jmp = (op == OP_JMP);

  // Request strobes drop in the same cycle reset is raised.
  assign imem_req  = (state == FETCH) & enable & ~rst;
  assign imem_addr = pc;
  assign dmem_req  = (state == MEM) & ~rst;
  assign dmem_we   = dmem_req & is_st;

  always_comb begin
    alu = '0;
    case (op[1:0])
      2'b00:   alu = src_a + src_b;
      2'b01:   alu = src_a - src_b;
      2'b10:   alu = src_a & src_b;
      default: alu = src_a | src_b;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= FETCH;
      pc         <= RESET_PC;
      instr      <= '0;
      src_a      <= '0;
      src_b      <= '0;
      src_c      <= '0;
      res        <= '0;
      dmem_addr  <= '0;
      dmem_wdata <= '0;
      for (int i = 0; i < 32; i++) regs[i] <= '0;
    end else begin
      unique case (state)
        FETCH: begin
          if (imem_req && imem_ack) begin
            instr <= imem_rdata;
            pc    <= pc + PC_W'(1);
            state <= DECODE;
          end
        end
        DECODE: begin
          src_a <= regs[rs1];
          src_b <= regs[rs2];
          src_c <= regs[rd];
          state <= EXECUTE;
        end
        EXECUTE: begin
          unique case (1'b1)
            is_alu: begin
              res   <= alu;
              state <= WB;
            end
            is_mem: begin
              dmem_addr  <= addr;
              dmem_wdata <= src_c;
              state      <= MEM;
            end
            default: begin
              // pc already points past this branch; taken overrides it
              if (is_jmp || src_c == src_a) pc <= tgt;
              state <= FETCH;
            end
          endcase
        end
        MEM: begin
          if (dmem_ack) begin
            res   <= dmem_rdata;
            state <= is_st ? FETCH : WB;
          end
        end
        WB: begin
          if (rd != 5'd0) regs[rd] <= res;
          state <= FETCH;
        end
        default: state <= FETCH;
      endcase
    end
  end

`ifdef MC_CORE_RETIRE_EN
  logic [PC_W-1:0] fetch_pc;

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc <= '0;
    end else if (imem_req && imem_ack) begin
      fetch_pc <= pc;
    end
  end

  assign retire_valid = ~rst & ((state == WB)
    | ((state == MEM) & dmem_ack & is_st)
    | ((state == EXECUTE) & ~is_alu & ~is_mem));
  assign retire_pc   = fetch_pc;
  assign retire_inst = instr;
`endif

endmodule
